dmux4way_sched: RTL and testbench

Credit-based round-robin dispatcher that shares one input stream across the four output lanes of a DMux4Way fan-out. It accepts words on a valid/ready handshake and picks the next lane with free credit. It drives the demux `sel` and a registered one-hot lane strobe. It sits directly in front of the DMux4Way datapath and is the only block allowed to drive its select.

---
 rtl/dmux4way_pkg.sv | 14 +
 rtl/rr_pick4.sv | 22 ++
 rtl/dmux4way_sched.sv | 105 ++++++++++
 tb/tb_dmux4way_sched.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dmux4way_pkg.sv
// Shared types and helpers for the DMux4Way credit dispatcher.
package dmux4way_pkg;

  localparam int unsigned LANES = 4;

  typedef logic [1:0]       lane_sel_t;
  typedef logic [LANES-1:0] lane_vec_t;

  // Convert a lane index to its one-hot strobe.
  function automatic lane_vec_t sel2onehot(input lane_sel_t s);
    sel2onehot = lane_vec_t'(1) << s;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker over four lanes, searching from ptr upward.
module rr_pick4
  import dmux4way_pkg::*;
(
  input  lane_vec_t elig,
  input  lane_sel_t ptr,
  output logic      any,
  output lane_sel_t pick
);

  // Highest offset first so the closest eligible lane to ptr wins.
  always_comb begin
    any  = |elig;
    pick = ptr;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (elig[ptr + lane_sel_t'(k)]) begin
        pick = ptr + lane_sel_t'(k);
      end
    end
  end

endmodule

// File: rtl/dmux4way_sched.sv
// Credit-based round-robin dispatcher feeding a DMux4Way fan-out.
// Optional feature: define DMUX4WAY_SCHED_MASK_EN to add the lane_en port.
module dmux4way_sched
  import dmux4way_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned CREDITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       credit_ret,
  output logic             cred_err
`ifdef DMUX4WAY_SCHED_MASK_EN
  ,
  input  logic [3:0]       lane_en
`endif
);

  localparam int unsigned    CW   = $clog2(CREDITS + 1);
  localparam logic [CW-1:0]  CMAX = CW'(CREDITS);

  logic [CW-1:0] cred     [LANES];
  logic [CW-1:0] cred_nxt [LANES];
  lane_sel_t     ptr;
  lane_sel_t     pick;
  lane_vec_t     elig;
  lane_vec_t     disp;
  logic          any;
  logic          xfer;
  logic          err_set;

  // Lane eligibility: free credit, gated by the enable mask when present.
  always_comb begin
    elig = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef DMUX4WAY_SCHED_MASK_EN
      elig[i] = (cred[i] != '0) && lane_en[i];
`else
      elig[i] = (cred[i] != '0);
`endif
    end
  end

  rr_pick4 u_pick (
    .elig (elig),
    .ptr  (ptr),
    .any  (any),
    .pick (pick)
  );

  assign in_ready = any;
  assign xfer     = in_valid & any;
  assign disp     = xfer ? sel2onehot(pick) : '0;

  // Per-lane credit update; a same-cycle return and dispatch cancel out.
  always_comb begin
    err_set = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      cred_nxt[i] = cred[i];
      if (disp[i] && !credit_ret[i]) begin
        cred_nxt[i] = cred[i] - CW'(1);
      end else if (!disp[i] && credit_ret[i]) begin
        if (cred[i] == CMAX) begin
          err_set = 1'b1;
        end else begin
          cred_nxt[i] = cred[i] + CW'(1);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        cred[i] <= CMAX;
      end
      ptr       <= '0;
      sel       <= '0;
      out_data  <= '0;
      out_valid <= '0;
      cred_err  <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        cred[i] <= cred_nxt[i];
      end
      cred_err <= cred_err | err_set;
      if (xfer) begin
        out_data  <= in_data;
        sel       <= pick;
        out_valid <= sel2onehot(pick);
        ptr       <= pick + lane_sel_t'(1);
      end else begin
        out_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmux4way_sched.sv
// Directed self-checking bench for dmux4way_sched (WIDTH=1, CREDITS=3).
module tb_dmux4way_sched;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [0:0] in_data;
  logic       in_ready;
  logic [1:0] sel;
  logic [0:0] out_data;
  logic [3:0] out_valid;
  logic [3:0] credit_ret;
  logic       cred_err;
`ifdef DMUX4WAY_SCHED_MASK_EN
  logic [3:0] lane_en;
`endif

  int n_vec;
  int n_err;

  dmux4way_sched #(.WIDTH(1), .CREDITS(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .sel        (sel),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .credit_ret (credit_ret),
    .cred_err   (cred_err)
`ifdef DMUX4WAY_SCHED_MASK_EN
    ,
    .lane_en    (lane_en)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = 1'b0;
    credit_ret = 4'b0000;
`ifdef DMUX4WAY_SCHED_MASK_EN
    lane_en    = 4'b1111;
`endif
    tick();
    tick();
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_sel",       32'(sel),       32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_cred_err",  32'(cred_err),  32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h1);

    // Twelve back-to-back words drain three credits from each lane in order.
    in_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_data = (k < 4) ? 1'b1 : 1'(k & 1);
      tick();
      chk("fill_out_valid", 32'(out_valid), 32'(4'b0001 << (k % 4)));
      chk("fill_sel",       32'(sel),       32'(k % 4));
      chk("fill_out_data",  32'(out_data),  32'(in_data));
    end
    chk("drained_in_ready", 32'(in_ready), 32'h0);

    // Stalled: no strobe, sel and data hold the last accepted word.
    in_data = 1'b0;
    tick();
    chk("stall_out_valid", 32'(out_valid), 32'h0);
    chk("stall_in_ready",  32'(in_ready),  32'h0);
    chk("stall_out_data",  32'(out_data),  32'h1);
    chk("stall_sel",       32'(sel),       32'h3);

    // Single return to lane 2 reopens the input and steers the next word there.
    in_valid   = 1'b0;
    credit_ret = 4'b0100;
    tick();
    credit_ret = 4'b0000;
    chk("ret2_in_ready", 32'(in_ready), 32'h1);
    in_valid = 1'b1;
    in_data  = 1'b0;
    tick();
    chk("ret2_out_valid", 32'(out_valid), 32'b0100);
    chk("ret2_sel",       32'(sel),       32'h2);
    chk("ret2_in_ready",  32'(in_ready),  32'h0);

    // Lane 1 at one credit: dispatch plus return in the same cycle keeps it at one.
    in_valid   = 1'b0;
    credit_ret = 4'b0010;
    tick();
    chk("l1_in_ready", 32'(in_ready), 32'h1);
    in_valid   = 1'b1;
    in_data    = 1'b1;
    credit_ret = 4'b0010;
    tick();
    credit_ret = 4'b0000;
    chk("same_out_valid", 32'(out_valid), 32'b0010);
    chk("same_sel",       32'(sel),       32'h1);
    chk("same_in_ready",  32'(in_ready),  32'h1);
    tick();
    chk("last_out_valid", 32'(out_valid), 32'b0010);
    chk("last_in_ready",  32'(in_ready),  32'h0);
    in_valid = 1'b0;

    // Refill lane 0 to the limit, then one more return raises the sticky error.
    credit_ret = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("refill_cred_err", 32'(cred_err), 32'h0);
    end
    tick();
    credit_ret = 4'b0000;
    chk("over_cred_err", 32'(cred_err), 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sticky_cred_err", 32'(cred_err), 32'h1);
    end

    // Reset clears the error; then reset lands in the middle of a burst.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_cred_err", 32'(cred_err), 32'h0);
    in_valid = 1'b1;
    in_data  = 1'b1;
    tick();
    chk("burst0_out_valid", 32'(out_valid), 32'b0001);
    tick();
    chk("burst1_out_valid", 32'(out_valid), 32'b0010);
    reset = 1'b1;
    tick();
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_sel",       32'(sel),       32'h0);
    chk("mid_rst_out_data",  32'(out_data),  32'h0);
    chk("mid_rst_cred_err",  32'(cred_err),  32'h0);
    reset = 1'b0;
    tick();
    chk("post_rst_out_valid", 32'(out_valid), 32'b0001);
    chk("post_rst_sel",       32'(sel),       32'h0);
    in_valid = 1'b0;
    tick();

`ifdef DMUX4WAY_SCHED_MASK_EN
    // Only lanes 1 and 3 enabled: strobes alternate between them.
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    lane_en  = 4'b1010;
    in_valid = 1'b1;
    in_data  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mask_out_valid", 32'(out_valid), (k % 2 == 0) ? 32'b0010 : 32'b1000);
      chk("mask_sel",       32'(sel),       (k % 2 == 0) ? 32'h1 : 32'h3);
    end
    reset = 1'b1;
    tick();
    chk("mask_rst_out_valid", 32'(out_valid), 32'h0);
    chk("mask_rst_sel",       32'(sel),       32'h0);
    chk("mask_rst_out_data",  32'(out_data),  32'h0);
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
